// File: rtl/btn_press_classifier.sv
// ---------------------------------------------------------------------------
// btn_press_classifier
//   Turns one raw board button into clean, single-cycle event pulses for the
//   LED mode/speed FSM: press, release, short press, long press, auto-repeat.
//
//   Ports
//     clk            system clock
//     rst_n          synchronous active-low reset
//     btn_in         raw asynchronous button level (1 = pressed)
//     btn_level      debounced, synchronized level
//     press_pulse    1-cycle pulse when btn_level rises
//     release_pulse  1-cycle pulse when btn_level falls
//     short_pulse    1-cycle pulse on release of a press shorter than LONG_CYC
//     long_pulse     1-cycle pulse when a hold reaches LONG_CYC
//     repeat_pulse   1-cycle pulse every REP_CYC while held after long_pulse
// ---------------------------------------------------------------------------
module btn_press_classifier #(
    parameter int CLK_HZ      = 125_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;

    // A count of 1 would give a zero-width counter; keep at least one bit.
    localparam int DW = (DB_CYC   > 1) ? $clog2(DB_CYC)   : 1;
    localparam int LW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam int RW = (REP_CYC  > 1) ? $clog2(REP_CYC)  : 1;

    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic          lvl_toggle, lvl_rise, lvl_fall;

    state_t        state, state_nxt;
    logic [LW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          press_nxt, release_nxt, short_nxt, long_nxt, repeat_nxt;

    // ---------------- synchronizer + debounce ----------------
    // The toggle condition is exposed combinationally so the FSM can register
    // its pulses on the very edge where btn_level changes.
    assign lvl_toggle = (sync[1] != btn_level) && (db_cnt == DB_LAST);
    assign lvl_rise   = lvl_toggle &&  sync[1];
    assign lvl_fall   = lvl_toggle && !sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync      <= '0;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            sync <= {sync[0], btn_in};
            if (sync[1] == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_level <= sync[1];
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            rep_cnt       <= rep_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            short_pulse   <= short_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // A fall always takes priority over the long / repeat thresholds.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (lvl_rise) state_nxt = PRESSED;
            PRESSED: begin
                if (lvl_fall)                   state_nxt = IDLE;
                else if (hold_cnt == LONG_LAST) state_nxt = LONG_HELD;
            end
            LONG_HELD: if (lvl_fall) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs and counters ----------------
    // Counters stop at their last value because the threshold branch always
    // leaves the state or clears the counter, so they never wrap.
    always_comb begin
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        hold_nxt    = hold_cnt;
        rep_nxt     = rep_cnt;
        case (state)
            IDLE: begin
                press_nxt = lvl_rise;
                hold_nxt  = '0;
            end
            PRESSED: begin
                if (lvl_fall) begin
                    release_nxt = 1'b1;
                    short_nxt   = 1'b1;
                end else if (hold_cnt == LONG_LAST) begin
                    long_nxt = 1'b1;
                    rep_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (lvl_fall) begin
                    release_nxt = 1'b1;
                end else if (rep_cnt == REP_LAST) begin
                    repeat_nxt = 1'b1;
                    rep_nxt    = '0;
                end else begin
                    rep_nxt = rep_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_btn_press_classifier
//   Scenario table of hold lengths with expected pulse counts and press edge,
//   hand-written reset-mid-hold sequence, and a randomized phase; every cycle
//   is also compared against an event-level reference model.
// ---------------------------------------------------------------------------
module tb_btn_press_classifier;

    localparam int DB = 4, LG = 20, RP = 5;

    logic clk = 1'b0, rst_n = 1'b0, btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

    btn_press_classifier #(
        .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .short_pulse(short_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // Reference model: input delay line, window of the last DB compared
    // samples, and press age measured in cycles since press_pulse.
    logic       m_d1 = 0, m_d2 = 0, m_lvl = 0, m_held = 0;
    int         m_age = 0;
    logic       m_win[$];
    logic [5:0] m_out = '0;

    int edge_no, press_at, c_press, c_rel, c_short, c_long, c_rep;

    typedef struct {
        int hi;
        int press_at;
        int n_press, n_rel, n_short, n_long, n_rep;
    } vec_t;

    vec_t vecs[$];

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b (lvl,press,rel,short,long,rep)",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic cmp, all_diff, rise, fall;
        m_out = '0;
        if (!r) begin
            m_d1 = 0; m_d2 = 0; m_lvl = 0; m_held = 0; m_age = 0;
            m_win.delete();
            return;
        end
        cmp  = m_d2;
        m_d2 = m_d1;
        m_d1 = b;
        m_win.push_back(cmp);
        if (m_win.size() > DB) void'(m_win.pop_front());
        all_diff = (m_win.size() == DB);
        foreach (m_win[i]) if (m_win[i] == m_lvl) all_diff = 0;
        rise = all_diff && !m_lvl;
        fall = all_diff &&  m_lvl;
        if (all_diff) m_lvl = ~m_lvl;
        m_out[5] = m_lvl;
        if (rise) begin
            m_out[4] = 1; m_held = 1; m_age = 0;
        end else if (m_held) begin
            m_age++;
            if (fall) begin
                m_out[3] = 1;
                m_out[2] = (m_age <= LG);
                m_held   = 0;
            end else if (m_age == LG) begin
                m_out[1] = 1;
            end else if (m_age > LG && (m_age - LG) % RP == 0) begin
                m_out[0] = 1;
            end
        end
    endtask

    task automatic clear_counts();
        edge_no = 0; press_at = -1;
        c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_rep = 0;
    endtask

    task automatic cyc(input logic b, input logic r);
        btn_in = b;
        rst_n  = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check6("cycle", {btn_level, press_pulse, release_pulse, short_pulse,
                         long_pulse, repeat_pulse}, m_out);
        edge_no++;
        if (press_pulse && press_at < 0) press_at = edge_no;
        c_press += int'(press_pulse);
        c_rel   += int'(release_pulse);
        c_short += int'(short_pulse);
        c_long  += int'(long_pulse);
        c_rep   += int'(repeat_pulse);
    endtask

    initial begin
        logic b;
        // hi, press edge, press, release, short, long, repeat
        vecs.push_back('{3,  -1, 0, 0, 0, 0, 0});  // glitch below debounce
        vecs.push_back('{4,   6, 1, 1, 1, 0, 0});  // exactly debounce length
        vecs.push_back('{10,  6, 1, 1, 1, 0, 0});  // short press
        vecs.push_back('{19,  6, 1, 1, 1, 0, 0});
        vecs.push_back('{20,  6, 1, 1, 1, 0, 0});  // fall on long threshold
        vecs.push_back('{21,  6, 1, 1, 0, 1, 0});
        vecs.push_back('{25,  6, 1, 1, 0, 1, 0});  // fall on repeat boundary
        vecs.push_back('{26,  6, 1, 1, 0, 1, 1});
        vecs.push_back('{40,  6, 1, 1, 0, 1, 3});  // long + repeats

        // Reset, then idle for 50 cycles.
        clear_counts();
        repeat (3)  cyc(1'b0, 1'b0);
        repeat (50) cyc(1'b0, 1'b1);
        check6("reset_idle", {btn_level, press_pulse, release_pulse, short_pulse,
                              long_pulse, repeat_pulse}, 6'b0);
        check_i("idle_pulses", c_press + c_rel + c_short + c_long + c_rep, 0);

        foreach (vecs[k]) begin
            clear_counts();
            repeat (vecs[k].hi) cyc(1'b1, 1'b1);
            repeat (40)         cyc(1'b0, 1'b1);
            check_i($sformatf("v%0d_press_at", vecs[k].hi), press_at, vecs[k].press_at);
            check_i($sformatf("v%0d_press",    vecs[k].hi), c_press,  vecs[k].n_press);
            check_i($sformatf("v%0d_release",  vecs[k].hi), c_rel,    vecs[k].n_rel);
            check_i($sformatf("v%0d_short",    vecs[k].hi), c_short,  vecs[k].n_short);
            check_i($sformatf("v%0d_long",     vecs[k].hi), c_long,   vecs[k].n_long);
            check_i($sformatf("v%0d_repeat",   vecs[k].hi), c_rep,    vecs[k].n_rep);
        end

        // Reset mid-hold: press at edge 6, reset at press+22 while LONG_HELD.
        clear_counts();
        repeat (27) cyc(1'b1, 1'b1);
        check_i("abort_long_seen", c_long, 1);
        repeat (2)  cyc(1'b1, 1'b0);
        check6("abort_reset_out", {btn_level, press_pulse, release_pulse, short_pulse,
                                   long_pulse, repeat_pulse}, 6'b0);
        clear_counts();
        repeat (10) cyc(1'b1, 1'b1);
        check_i("abort_repress_at", press_at, 6);
        check_i("abort_no_release", c_rel + c_short, 0);
        repeat (40) cyc(1'b0, 1'b1);
        check_i("abort_release", c_rel, 1);
        check_i("abort_short", c_short, 1);

        // Randomized runs, occasional reset.
        b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int len;
            len = $urandom_range(1, 45);
            b   = ~b;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) cyc(b, 1'b0);
            end
            repeat (len) cyc(b, 1'b1);
        end
        repeat (40) cyc(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
